spi_read_scheduler: RTL and testbench

SPI_READ_SCHEDULER -- requirements
Module: spi_read_scheduler

---
 rtl/spi_read_scheduler_if.sv | 44 ++++
 rtl/spi_read_scheduler.sv | 165 ++++++++++++++++
 tb/tb_spi_read_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_read_scheduler_if.sv
// Job queue / SD reader handshake bundle for spi_read_scheduler.
// Latency: none; this file only groups wires.
// Backpressure: job_ready from the scheduler throttles the host's job_valid.
// Ports:
//   slave  - scheduler side: takes job_* / flush / rd_irq / rd_error; drives
//            job_ready, rd_* descriptor, rd_start, done_*, busy, queue_count.
//   master - host/reader side: the mirror image.
interface spi_read_scheduler_if #(
  parameter int DEPTH = 4
);
  logic                     job_valid;
  logic                     job_ready;
  logic [31:0]              job_addr;
  logic [15:0]              job_sector;
  logic [15:0]              job_len;
  logic [3:0]               job_tag;
  logic                     flush;
  logic [31:0]              rd_startaddr;
  logic [15:0]              rd_sector;
  logic [15:0]              rd_len_sector;
  logic                     rd_start;
  logic                     rd_irq;
  logic                     rd_error;
  logic                     done;
  logic                     done_ok;
  logic [3:0]               done_tag;
  logic [1:0]               done_tries;
  logic                     busy;
  logic [$clog2(DEPTH):0]   queue_count;

  modport slave (
    input  job_valid, job_addr, job_sector, job_len, job_tag, flush,
    input  rd_irq, rd_error,
    output job_ready, rd_startaddr, rd_sector, rd_len_sector, rd_start,
    output done, done_ok, done_tag, done_tries, busy, queue_count
  );

  modport master (
    output job_valid, job_addr, job_sector, job_len, job_tag, flush,
    output rd_irq, rd_error,
    input  job_ready, rd_startaddr, rd_sector, rd_len_sector, rd_start,
    input  done, done_ok, done_tag, done_tries, busy, queue_count
  );
endinterface

// File: rtl/spi_read_scheduler.sv
// Queues SD read jobs and drives a sector reader one job at a time, with retry on error.
// Latency: push->rd_start 2 cycles when idle; rd_irq->done 2 cycles; null job push->done 2 cycles.
// Backpressure: job_ready drops when the queue holds DEPTH jobs or flush is asserted.
// Ports: clk, rst (async active-low), bus (slave modport of spi_read_scheduler_if).
module spi_read_scheduler #(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic               clk,
  input  logic               rst,
  spi_read_scheduler_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT  = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE   = 1;
  localparam logic [PW-1:0] PTR_ONE   = 1;
  localparam logic [1:0]    RETRY_LIM = MAX_RETRY[1:0];

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] sector;
    logic [15:0] len;
    logic [3:0]  tag;
  } job_t;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EVAL, REPORT} state_t;

  job_t          mem [DEPTH];
  job_t          head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  state_t        state, state_nxt;

  logic [31:0]   cur_addr;
  logic [15:0]   cur_sector;
  logic [15:0]   cur_len_m1;
  logic [3:0]    cur_tag;
  logic [1:0]    tries;
  logic          err_seen;
  logic          ok_q;

  logic          push, pop, load_desc, clr_err, inc_tries, set_ok, ok_val;

  assign head          = mem[rd_ptr];
  assign bus.job_ready = rst && !bus.flush && (count < FULL_CNT);
  assign push          = bus.job_valid && bus.job_ready;

  // Queue pointers and occupancy. Flush empties the queue but leaves the
  // job already latched in the current registers alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: bus.job_addr, sector: bus.job_sector,
                               len: bus.job_len, tag: bus.job_tag};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_desc = 1'b0;
    clr_err   = 1'b0;
    inc_tries = 1'b0;
    set_ok    = 1'b0;
    ok_val    = 1'b0;
    case (state)
      IDLE: begin
        // A flush in the same cycle wins: the head is discarded, not started.
        if (count != '0 && !bus.flush) begin
          pop = 1'b1;
          if (head.len != 16'd0) begin
            load_desc = 1'b1;
            state_nxt = ISSUE;
          end else begin
            set_ok    = 1'b1;
            ok_val    = 1'b1;
            state_nxt = REPORT;
          end
        end
      end
      ISSUE: begin
        clr_err   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.rd_irq) state_nxt = EVAL;
      end
      EVAL: begin
        if (err_seen && (tries < RETRY_LIM)) begin
          inc_tries = 1'b1;
          state_nxt = ISSUE;
        end else begin
          set_ok    = 1'b1;
          ok_val    = !err_seen;
          state_nxt = REPORT;
        end
      end
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Current job registers. The descriptor is only reloaded on a non-null pop,
  // so it is held untouched across retries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_addr   <= '0;
      cur_sector <= '0;
      cur_len_m1 <= '0;
      cur_tag    <= '0;
      tries      <= '0;
      err_seen   <= 1'b0;
      ok_q       <= 1'b0;
    end else begin
      if (pop) begin
        cur_tag <= head.tag;
        tries   <= '0;
      end
      if (load_desc) begin
        cur_addr   <= head.addr;
        cur_sector <= head.sector;
        cur_len_m1 <= head.len - 16'd1;
      end
      if (inc_tries) tries <= tries + 2'd1;
      // An error coinciding with rd_irq is still captured before EVAL.
      if (clr_err)                          err_seen <= 1'b0;
      else if (state == WAIT && bus.rd_error) err_seen <= 1'b1;
      if (set_ok) ok_q <= ok_val;
    end
  end

  assign bus.rd_startaddr  = cur_addr;
  assign bus.rd_sector     = cur_sector;
  assign bus.rd_len_sector = cur_len_m1;
  assign bus.rd_start      = (state == ISSUE);
  assign bus.done          = (state == REPORT);
  assign bus.done_ok       = bus.done && ok_q;
  assign bus.done_tag      = bus.done ? cur_tag : 4'd0;
  assign bus.done_tries    = bus.done ? tries : 2'd0;
  assign bus.busy          = (state != IDLE) || (count != '0);
  assign bus.queue_count   = count;
endmodule

// File: tb/tb_spi_read_scheduler.sv
module tb_spi_read_scheduler;
  localparam int DEPTH = 4;
  localparam int MAXR  = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] sector;
    logic [15:0] len;
    logic [3:0]  tag;
  } job_t;

  logic clk;
  logic rst;
  spi_read_scheduler_if #(.DEPTH(DEPTH)) bus();

  spi_read_scheduler #(.DEPTH(DEPTH), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // staged stimulus, applied at the start of the next cycle
  logic s_rst, s_valid, s_flush;
  job_t s_job;

  // reference model
  job_t mq[$];
  job_t m_cur;
  bit   m_active, m_reading, m_err, m_ok, m_accepted;
  int   m_tries, m_start_at, m_done_at;

  // reader emulation
  int   rd_wait, rd_lat, attempt, lat_min, lat_max;
  bit [2:0] err_plan, fixed_plan;
  bit   force_plan, spur_en;

  // observed event log
  int   n_start, n_done, last_start_cyc, last_done_cyc, last_irq_cyc;
  logic [31:0] last_sa;
  logic [15:0] last_sec, last_len;
  int   done_tags[$];
  int   done_oks[$];
  int   done_tries_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic new_attempt();
    rd_wait = 0;
    rd_lat  = $urandom_range(lat_min, lat_max);
  endtask

  task automatic cycle();
    bit e_ready, e_start, e_done, popped;
    @(negedge clk);
    rst            = s_rst;
    bus.job_valid  = s_valid;
    bus.job_addr   = s_job.addr;
    bus.job_sector = s_job.sector;
    bus.job_len    = s_job.len;
    bus.job_tag    = s_job.tag;
    bus.flush      = s_flush;
    bus.rd_irq     = 1'b0;
    bus.rd_error   = 1'b0;
    if (rst && m_reading) begin
      if (rd_wait == rd_lat) bus.rd_irq = 1'b1;
      // odd latency: error with the irq; even latency: one cycle earlier
      if (attempt < 3 && err_plan[attempt] &&
          ((rd_lat[0] && rd_wait == rd_lat) || (!rd_lat[0] && rd_wait == rd_lat - 1)))
        bus.rd_error = 1'b1;
    end else if (rst && spur_en && $urandom_range(0, 7) == 0) begin
      bus.rd_irq = 1'b1;
    end
    #1;
    e_ready = rst && (mq.size() < DEPTH) && !bus.flush;
    if (!rst) begin
      check("rst_job_ready", bus.job_ready, 0);
      check("rst_rd_start", bus.rd_start, 0);
      check("rst_done", {bus.done, bus.done_ok, bus.done_tag, bus.done_tries}, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_count", bus.queue_count, 0);
      check("rst_desc", {bus.rd_startaddr, bus.rd_sector, bus.rd_len_sector}, 0);
    end else begin
      e_start = (cyc == m_start_at);
      e_done  = (cyc == m_done_at);
      check("job_ready", bus.job_ready, e_ready);
      check("queue_count", bus.queue_count, mq.size());
      check("busy", bus.busy, m_active || mq.size() != 0);
      check("rd_start", bus.rd_start, e_start);
      check("done", bus.done, e_done);
      if (e_done) begin
        check("done_ok", bus.done_ok, m_ok);
        check("done_tag", bus.done_tag, m_cur.tag);
        check("done_tries", bus.done_tries, m_tries);
      end
      if (m_active && m_cur.len != 0) begin
        check("rd_startaddr", bus.rd_startaddr, m_cur.addr);
        check("rd_sector", bus.rd_sector, m_cur.sector);
        check("rd_len_sector", bus.rd_len_sector, m_cur.len - 16'd1);
      end
    end
    // event log from what the DUT actually did
    if (bus.rd_start) begin
      n_start++;
      last_start_cyc = cyc;
      last_sa  = bus.rd_startaddr;
      last_sec = bus.rd_sector;
      last_len = bus.rd_len_sector;
    end
    if (bus.done) begin
      n_done++;
      last_done_cyc = cyc;
      done_tags.push_back(int'(bus.done_tag));
      done_oks.push_back(int'(bus.done_ok));
      done_tries_q.push_back(int'(bus.done_tries));
    end
    if (m_reading && bus.rd_irq) last_irq_cyc = cyc;
    // model update for the coming edge
    m_accepted = 1'b0;
    if (!rst) begin
      mq.delete();
      m_active = 0; m_reading = 0; m_tries = 0;
      m_start_at = -1; m_done_at = -1;
    end else begin
      if (m_reading) begin
        if (bus.rd_error) m_err = 1;
        if (bus.rd_irq) begin
          m_reading = 0;
          attempt++;
          if (m_err && m_tries < MAXR) begin
            m_tries++;
            m_start_at = cyc + 2;
          end else begin
            m_ok = !m_err;
            m_done_at = cyc + 2;
          end
        end else begin
          rd_wait++;
        end
      end
      if (cyc == m_start_at) begin
        m_reading = 1;
        m_err = 0;
        new_attempt();
      end
      popped = 0;
      if (!m_active && mq.size() > 0 && !bus.flush) begin
        m_cur = mq.pop_front();
        m_active = 1; m_tries = 0; popped = 1; attempt = 0;
        err_plan = force_plan ? fixed_plan :
                   (($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000);
        if (m_cur.len != 0) m_start_at = cyc + 1;
        else begin
          m_ok = 1;
          m_done_at = cyc + 1;
        end
      end
      if (cyc == m_done_at && !popped) m_active = 0;
      if (bus.flush) mq.delete();
      else if (bus.job_valid && e_ready) begin
        mq.push_back(s_job);
        m_accepted = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic push_job(input job_t j, output int acc_cyc);
    acc_cyc = -1;
    for (int k = 0; k < 300; k++) begin
      s_valid = 1'b1;
      s_job   = j;
      cycle();
      if (m_accepted) begin
        acc_cyc = cyc - 1;
        break;
      end
    end
    s_valid = 1'b0;
    if (acc_cyc < 0) check("push_timeout", 0, 1);
  endtask

  task automatic run_until_done(input int target, input string name);
    for (int k = 0; k < 400 && n_done < target; k++) cycle();
    if (n_done < target) check(name, 0, 1);
  endtask

  task automatic run_until_start(input int target, input string name);
    for (int k = 0; k < 400 && n_start < target; k++) cycle();
    if (n_start < target) check(name, 0, 1);
  endtask

  initial begin
    int pc, s0, d0;
    job_t j;
    rst = 1'b0; s_rst = 1'b0; s_valid = 1'b0; s_flush = 1'b0; s_job = '0;
    bus.job_valid = 1'b0; bus.job_addr = '0; bus.job_sector = '0; bus.job_len = '0;
    bus.job_tag = '0; bus.flush = 1'b0; bus.rd_irq = 1'b0; bus.rd_error = 1'b0;
    m_start_at = -1; m_done_at = -1; m_active = 0; m_reading = 0;
    lat_min = 1; lat_max = 4; force_plan = 1; fixed_plan = 3'b000; spur_en = 0;
    attempt = 0; rd_wait = 0; rd_lat = 1; n_start = 0; n_done = 0;

    // reset state
    cycle(); cycle();
    s_rst = 1'b1;
    cycle();
    check("ready_after_rst", bus.job_ready, 1);

    // basic job
    j = '{addr: 32'h1000, sector: 16'd5, len: 16'd3, tag: 4'd2};
    push_job(j, pc);
    run_until_done(1, "t1_timeout");
    check("t1_start_lat", last_start_cyc - pc, 2);
    check("t1_len", last_len, 2);
    check("t1_sector", last_sec, 5);
    check("t1_addr", last_sa, 32'h1000);
    check("t1_done_lat", last_done_cyc - last_irq_cyc, 2);
    check("t1_result", {done_oks[$], done_tags[$], done_tries_q[$]}, {32'd1, 32'd2, 32'd0});

    // two errors, clean third attempt
    fixed_plan = 3'b011;
    s0 = n_start;
    push_job(j, pc);
    run_until_done(2, "t2_timeout");
    check("t2_starts", n_start - s0, 3);
    check("t2_len", last_len, 2);
    check("t2_result", {done_oks[$], done_tries_q[$]}, {32'd1, 32'd2});

    // all attempts fail, next job then runs
    fixed_plan = 3'b111;
    s0 = n_start;
    j.tag = 4'd3;
    push_job(j, pc);
    j.tag = 4'd4; j.addr = 32'h2000;
    push_job(j, pc);
    run_until_done(3, "t3a_timeout");
    check("t3_starts", n_start - s0, 3);
    check("t3_result", {done_oks[$], done_tags[$], done_tries_q[$]}, {32'd0, 32'd3, 32'd2});
    fixed_plan = 3'b000;
    run_until_done(4, "t3b_timeout");
    check("t3_next", {done_oks[$], done_tags[$]}, {32'd1, 32'd4});

    // fill the queue behind an in-flight job
    lat_min = 15; lat_max = 15;
    for (int i = 0; i < 10; i++) cycle();
    s0 = n_start; d0 = n_done;
    j = '{addr: 32'h3000, sector: 16'd9, len: 16'd2, tag: 4'd1};
    push_job(j, pc);
    run_until_start(s0 + 1, "t4_start_timeout");
    for (int t = 2; t <= 4; t++) begin
      j.tag = 4'(t); j.addr = j.addr + 32'h100;
      push_job(j, pc);
    end
    j.tag = 4'd5;
    push_job(j, pc);
    s_valid = 1'b1; s_job = '{addr: 32'h4000, sector: 16'd1, len: 16'd1, tag: 4'd6};
    cycle();
    check("t4_full_ready", bus.job_ready, 0);
    check("t4_full_count", bus.queue_count, 4);
    push_job(s_job, pc);
    run_until_done(d0 + 6, "t4_done_timeout");
    for (int t = 0; t < 6; t++) check("t4_order", done_tags[d0 + t], t + 1);

    // null job
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 5; i++) cycle();
    s0 = n_start; d0 = n_done;
    j = '{addr: 32'h5000, sector: 16'd7, len: 16'd0, tag: 4'd7};
    push_job(j, pc);
    run_until_done(d0 + 1, "t5_timeout");
    check("t5_done_lat", last_done_cyc - pc, 2);
    check("t5_no_start", n_start - s0, 0);
    check("t5_result", {done_oks[$], done_tags[$], done_tries_q[$]}, {32'd1, 32'd7, 32'd0});

    // flush with three queued and one in flight
    lat_min = 15; lat_max = 15;
    s0 = n_start; d0 = n_done;
    j = '{addr: 32'h6000, sector: 16'd2, len: 16'd4, tag: 4'd8};
    push_job(j, pc);
    run_until_start(s0 + 1, "t6_start_timeout");
    for (int t = 9; t <= 11; t++) begin
      j.tag = 4'(t);
      push_job(j, pc);
    end
    cycle();
    check("t6_count3", bus.queue_count, 3);
    s_flush = 1'b1;
    cycle();
    s_flush = 1'b0;
    cycle();
    check("t6_count0", bus.queue_count, 0);
    run_until_done(d0 + 1, "t6_timeout");
    check("t6_tag", done_tags[$], 8);
    for (int i = 0; i < 30; i++) cycle();
    check("t6_one_done", n_done - d0, 1);
    check("t6_idle", bus.busy, 0);

    // reset while the reader is busy abandons the job
    s0 = n_start; d0 = n_done;
    j.tag = 4'd12;
    push_job(j, pc);
    run_until_start(s0 + 1, "t7_start_timeout");
    cycle(); cycle();
    s_rst = 1'b0;
    cycle();
    s_rst = 1'b1;
    for (int i = 0; i < 30; i++) cycle();
    check("t7_no_done", n_done - d0, 0);
    check("t7_idle", bus.busy, 0);

    // randomized traffic
    lat_min = 1; lat_max = 4; force_plan = 0; spur_en = 1;
    for (int i = 0; i < 1500; i++) begin
      s_valid      = ($urandom_range(0, 2) == 0);
      s_job.addr   = $urandom;
      s_job.sector = 16'($urandom);
      s_job.len    = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
      s_job.tag    = 4'($urandom);
      s_flush      = ($urandom_range(0, 39) == 0);
      cycle();
    end
    s_valid = 1'b0; s_flush = 1'b0; spur_en = 0;
    for (int k = 0; k < 500 && (m_active || mq.size() != 0); k++) cycle();
    cycle();
    check("drain_busy", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
